shift_right_sequencer: RTL and testbench
========================================

Name: shift_right_sequencer

Overview:
Multi-cycle logical right shifter controller. It accepts an operand and shift amount over a valid/ready handshake. It resolves the shift one shift-amount bit per cycle, reusing one fixed_shift_right stage of size 2^k selected by a stage counter. The result is returned over a valid/ready handshake. This lets the execution datapath trade barrel-shifter area for latency.

Parameters:
WIDTH, 64, operand width in bits; must be a power of two and at least 2.
SHW, $clog2(WIDTH), shift-amount width; derived, never overridden.

Ports:
clk  input  1  clock, all state updates on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept a request (high only in IDLE)
in_data  input  WIDTH  operand to shift
in_shamt  input  SHW  unsigned shift amount, 0..WIDTH-1
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  shifted result, zero-filled from the MSB side
busy  output  1  high in SHIFT or DONE

Behaviour:
- Registers: state, acc[WIDTH], sh[SHW], k (stage counter, SHW bits, or 1 bit when SHW=1).
- Stage mux: acc_next = acc >> 2^k when sh[k]=1, else acc. Built as SHW fixed_shift_right instances (SHAMT=1,2,4,..,WIDTH/2); shift = (k==i) & sh[i]; output selected by k.
- States and transitions:
  - IDLE: in_ready=1. When in_valid=1 at an edge: acc<=in_data, sh<=in_shamt, k<=0, go to SHIFT.
  - SHIFT: each edge acc<=acc_next.
    - last = (k==SHW-1) or (sh >> (k+1)) == 0, i.e. no higher shamt bits remain.
    - If last: go to DONE. Otherwise k<=k+1.
  - DONE: out_valid=1, out_data=acc, held stable. When out_ready=1 at an edge, go to IDLE.
- Latency:
  - n = max(1, msb_index(in_shamt)+1) SHIFT cycles.
  - With the accept at edge T, out_valid is high in the cycle after edge T+n.
  - shamt=0 still spends 1 SHIFT cycle.
- Throughput: no bypass from DONE to IDLE. Minimum spacing between accepts is n+2 cycles.
- in_valid during SHIFT or DONE is ignored (in_ready=0). in_data and in_shamt are sampled only at the accept edge.
- out_ready while out_valid=0 has no effect.
- Arithmetic: logical shift only, vacated MSBs are 0. shamt >= WIDTH cannot occur, because of the SHW width.
- Reset (at any edge, including mid-SHIFT or in DONE with out_ready low):
  - state<=IDLE, acc<=0, sh<=0, k<=0.
  - out_valid=0, out_data=0, busy=0, in_ready=1 in the next cycle.
  - The in-flight request is discarded with no output.
  - reset dominates a simultaneous in_valid or out_ready.
- out_data is driven from acc in all states and is meaningful only while out_valid=1.

Test Plan:
Use WIDTH=8, SHW=3 throughout.
- in_data=0x80, in_shamt=7, out_ready=1 -> 3 SHIFT cycles; out_valid in cycle after edge T+3; out_data=0x01; back to IDLE next edge.
- in_data=0xB5, in_shamt=0 -> 1 SHIFT cycle; out_data=0xB5.
- in_data=0xF0, in_shamt=2 -> n=2; out_data=0x3C. Then in_shamt=4 -> n=3; out_data=0x0F.
- Backpressure: in_data=0xFF, in_shamt=1, out_ready=0 for 5 cycles -> out_valid and out_data=0x7F held stable; in_ready=0 throughout; a second in_valid pulse (0x11) is ignored; releases on out_ready=1.
- Reset mid-operation: accept 0x80 shamt=6, assert reset on the 2nd SHIFT edge -> next cycle busy=0, out_valid=0, out_data=0, in_ready=1. A new request 0x40 shamt=1 then yields 0x20.
- Exhaustive sweep: every in_shamt 0..7 with random in_data, checked against a reference logical right shift. Each request's latency is checked to equal max(1, msb+1) SHIFT cycles.

Source files
------------

// File: rtl/shift_right_sequencer_if.sv
// Request/response bundle for shift_right_sequencer: operand handshake in,
// result handshake out, plus the busy status flag.
interface shift_right_sequencer_if #(
  parameter int WIDTH = 64
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_data, in_shamt, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_shamt, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/shift_right_sequencer.sv
// Multi-cycle logical right shifter: resolves one shift-amount bit per cycle
// through a bank of fixed power-of-two stages selected by a stage counter.

module fixed_shift_right #(
  parameter int WIDTH = 64,
  parameter int SHAMT = 1
) (
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  assign dout = shift ? (din >> SHAMT) : din;
endmodule

module shift_right_sequencer #(
  parameter int WIDTH = 64
) (
  input logic                    clk,
  input logic                    reset,
  shift_right_sequencer_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   sh_q, sh_d;
  logic [SHW-1:0]   k_q, k_d;

  logic [WIDTH-1:0] stage_out [SHW];
  logic [WIDTH-1:0] acc_next;
  logic             more_bits;

  // Only the stage addressed by k may shift; the rest pass through unused.
  for (genvar i = 0; i < SHW; i++) begin : g_stage
    fixed_shift_right #(
      .WIDTH (WIDTH),
      .SHAMT (1 << i)
    ) u_stage (
      .shift ((k_q == SHW'(i)) && sh_q[i]),
      .din   (acc_q),
      .dout  (stage_out[i])
    );
  end

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    acc_next  = acc_q;
    more_bits = 1'b0;
    for (int i = 0; i < SHW; i++) begin
      if (k_q == SHW'(i)) acc_next = stage_out[i];
      if ((SHW'(i) > k_q) && sh_q[i]) more_bits = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d   = bus.in_data;
          sh_d    = bus.in_shamt;
          k_d     = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = acc_next;
        // Stop as soon as no higher shift-amount bits remain to be applied.
        if (more_bits) k_d = k_q + 1'b1;
        else           state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sh_q    <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      k_q     <= k_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_data  = acc_q;

endmodule

// File: tb/tb_shift_right_sequencer.sv
// Self-checking bench for shift_right_sequencer at WIDTH=8: vector table,
// backpressure, mid-operation reset and a full shift-amount sweep.
module tb_shift_right_sequencer;
  localparam int WIDTH = 8;
  localparam int MAX_WAIT = 50;

  logic clk;
  logic reset;

  shift_right_sequencer_if #(.WIDTH(WIDTH)) bus ();

  shift_right_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [2:0] s;
    logic [7:0] exp_d;
    int         exp_l;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_lat(input logic [2:0] s);
    int lat = 1;
    for (int i = 0; i < 3; i++) if (s[i]) lat = i + 1;
    return lat;
  endfunction

  task automatic accept(input logic [7:0] d, input logic [2:0] s,
                        input logic [7:0] exp_d, input int exp_l);
    int waited = 0;
    while (!bus.in_ready && waited < MAX_WAIT) begin
      step();
      waited++;
    end
    if (waited == MAX_WAIT) check("in_ready_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = s;
    exp_q.push_back('{d: exp_d, lat: exp_l});
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    bus.in_shamt = 3'($urandom);
  endtask

  // Called right after accept(); expects out_ready already high.
  task automatic collect(input string name);
    int   cycles = 0;
    exp_t e;
    while (!bus.out_valid && cycles < MAX_WAIT) begin
      step();
      cycles++;
    end
    if (cycles == MAX_WAIT) begin
      check({name, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    check({name, "_latency"}, 64'(cycles), 64'(e.lat));
    check({name, "_data"}, 64'(bus.out_data), 64'(e.d));
    step();
    check({name, "_idle_after"}, {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
  endtask

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{d: 8'h80, s: 3'd7, exp_d: 8'h01, exp_l: 3};
    vecs[1] = '{d: 8'hB5, s: 3'd0, exp_d: 8'hB5, exp_l: 1};
    vecs[2] = '{d: 8'hF0, s: 3'd2, exp_d: 8'h3C, exp_l: 2};
    vecs[3] = '{d: 8'hF0, s: 3'd4, exp_d: 8'h0F, exp_l: 3};
    vecs[4] = '{d: 8'hFF, s: 3'd5, exp_d: 8'h07, exp_l: 3};
    vecs[5] = '{d: 8'hA5, s: 3'd3, exp_d: 8'h14, exp_l: 2};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("reset_in_ready",  64'(bus.in_ready),  64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_busy",      64'(bus.busy),      64'd0);
    check("reset_out_data",  64'(bus.out_data),  64'd0);

    for (int i = 0; i < 6; i++) begin
      accept(vecs[i].d, vecs[i].s, vecs[i].exp_d, vecs[i].exp_l);
      check($sformatf("vec%0d_busy", i), 64'(bus.busy), 64'd1);
      collect($sformatf("vec%0d", i));
    end

    // Backpressure: result must hold while out_ready is low; extra request ignored.
    bus.out_ready = 1'b0;
    accept(8'hFF, 3'd1, 8'h7F, 1);
    step();
    check("bp_first_valid", 64'(bus.out_valid), 64'd1);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h11;
        bus.in_shamt = 3'd0;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      check($sformatf("bp_hold%0d", c),
            {46'd0, bus.out_valid, bus.in_ready, bus.busy, bus.out_data, 7'd0},
            {46'd0, 1'b1, 1'b0, 1'b1, 8'h7F, 7'd0});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    void'(exp_q.pop_front());
    step();
    check("bp_release", {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("bp_no_ghost%0d", c), {62'd0, bus.busy, bus.out_valid}, 64'd0);
    end

    // Reset on the second SHIFT edge discards the request.
    accept(8'h80, 3'd6, 8'h02, 3);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    check("rst_mid_busy",      64'(bus.busy),      64'd0);
    check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid_out_data",  64'(bus.out_data),  64'd0);
    check("rst_mid_in_ready",  64'(bus.in_ready),  64'd1);
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("rst_mid_quiet%0d", c), 64'(bus.out_valid), 64'd0);
    end
    accept(8'h40, 3'd1, 8'h20, 1);
    collect("post_reset");

    for (int s = 0; s < 8; s++) begin
      logic [7:0] d;
      d = 8'($urandom);
      accept(d, 3'(s), d >> s, ref_lat(3'(s)));
      collect($sformatf("sweep_s%0d_d%02h", s, d));
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
